// File: rtl/atm_disp_pkg.sv
// rtl/atm_disp_pkg.sv - shared char codes, glyph table and display defaults
// Contents: default timing parameters, 5-bit character code constants,
// the 32-entry active-low glyph table (bit 6 = seg a .. bit 0 = seg g)
// and the per-slot scan state type.
package atm_disp_pkg;

    localparam int DEF_REFRESH_DIV  = 100000;
    localparam int DEF_GUARD_TICKS  = 4;
    localparam int DEF_BLINK_FRAMES = 64;

    localparam int NUM_DIGITS = 8;
    localparam int CHAR_W     = 5;
    localparam int SEG_W      = 7;

    localparam logic [CHAR_W-1:0] CH_BLANK = 5'd0;
    localparam logic [CHAR_W-1:0] CH_A = 5'd1,  CH_B = 5'd2,  CH_C = 5'd3,  CH_D = 5'd4;
    localparam logic [CHAR_W-1:0] CH_E = 5'd5,  CH_F = 5'd6,  CH_G = 5'd7,  CH_H = 5'd8;
    localparam logic [CHAR_W-1:0] CH_I = 5'd9,  CH_J = 5'd10, CH_K = 5'd11, CH_L = 5'd12;
    localparam logic [CHAR_W-1:0] CH_M = 5'd13, CH_N = 5'd14, CH_O = 5'd15, CH_P = 5'd16;
    localparam logic [CHAR_W-1:0] CH_Q = 5'd17, CH_R = 5'd18, CH_S = 5'd19, CH_T = 5'd20;
    localparam logic [CHAR_W-1:0] CH_U = 5'd21, CH_V = 5'd22, CH_W = 5'd23, CH_X = 5'd24;
    localparam logic [CHAR_W-1:0] CH_Y = 5'd25, CH_Z = 5'd26;

    // Listed from code 31 down to code 0; codes 27..31 and 0 are blank.
    localparam logic [31:0][SEG_W-1:0] GLYPH_TABLE = '{
        7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,          // 31..27 blank
        7'h12, 7'h44, 7'h48, 7'h55, 7'h63,          // Z Y X W V
        7'h41, 7'h70, 7'h24, 7'h7A, 7'h0C,          // U T S R Q
        7'h18, 7'h01, 7'h6A, 7'h2B, 7'h71,          // P O N M L
        7'h28, 7'h43, 7'h79, 7'h48, 7'h21,          // K J I H G
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60,          // F E D C B
        7'h08, 7'h7F                                // A blank
    };

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } slot_state_e;

endpackage

// File: rtl/char_glyph_rom.sv
// rtl/char_glyph_rom.sv - combinational 5-bit char code to 7-segment glyph lookup
// Ports: code  - character code (0 blank, 1..26 A..Z, 27..31 blank)
//        glyph - active-low segments a..g on glyph[6]..glyph[0]
module char_glyph_rom
    import atm_disp_pkg::*;
(
    input  logic [CHAR_W-1:0] code,
    output logic [SEG_W-1:0]  glyph
);

    assign glyph = GLYPH_TABLE[code];

endmodule

// File: rtl/msg_scan_driver.sv
// rtl/msg_scan_driver.sv - eight-digit multiplexed 7-segment message scanner
// Ports: clk, reset (sync, active-low)
//        msg/msg_valid/msg_ready - 8 x 5-bit message, accepted once per frame
//        blink                   - flash request, sampled at frame boundaries
//        AN                      - active-low anodes, slot k drives AN[k]
//        led                     - active-low segments a..g on led[6]..led[0]
//        frame_start             - pulse on the first tick of slot 0
module msg_scan_driver
    import atm_disp_pkg::*;
#(
    parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
    parameter int GUARD_TICKS  = DEF_GUARD_TICKS,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [39:0] msg,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic        blink,
    output logic [7:0]  AN,
    output logic [6:0]  led,
    output logic        frame_start
);

    localparam int TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BCNT_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
    localparam logic [TICK_W-1:0] GUARD_END = TICK_W'(GUARD_TICKS);

    // Counters hold the scan position whose outputs are registered at the
    // next edge, so AN/led appear one cycle after the position they encode.
    logic [TICK_W-1:0] tick, tick_nxt;
    logic [2:0]        slot, slot_nxt;
    slot_state_e       state, state_nxt;
    logic [39:0]       disp_msg, disp_nxt;
    logic [BCNT_W-1:0] blink_cnt, blink_cnt_nxt;
    logic              blink_phase, blink_phase_nxt;

    logic              tick_last;
    logic              frame_edge;
    logic              slot_end;
    logic              accept;
    logic [CHAR_W-1:0] chars [NUM_DIGITS];
    logic [CHAR_W-1:0] code_sel;
    logic [SEG_W-1:0]  glyph;
    logic [7:0]        an_d;
    logic [6:0]        led_d;

    assign tick_last  = (tick == TICK_LAST);
    assign frame_edge = (slot == 3'd0) && (tick == '0);
    assign slot_end   = (slot == 3'd7) && tick_last;
    assign tick_nxt   = tick_last ? '0 : tick + TICK_W'(1);
    assign slot_nxt   = tick_last ? slot + 3'd1 : slot;

    // msg_ready is only high in the cycle right before a frame boundary, so
    // an accept always coincides with frame_edge and never tears a frame.
    assign accept   = msg_valid && msg_ready;
    assign disp_nxt = accept ? msg : disp_msg;

    // Blink bookkeeping: blink_cnt is the number of frames already shown in
    // the current phase; the phase flips once that reaches BLINK_FRAMES.
    always_comb begin
        blink_cnt_nxt   = blink_cnt;
        blink_phase_nxt = blink_phase;
        if (frame_edge) begin
            if (!blink) begin
                blink_cnt_nxt   = '0;
                blink_phase_nxt = 1'b0;
            end else if (blink_cnt == BCNT_W'(BLINK_FRAMES)) begin
                blink_cnt_nxt   = BCNT_W'(1);
                blink_phase_nxt = ~blink_phase;
            end else begin
                blink_cnt_nxt   = blink_cnt + BCNT_W'(1);
            end
        end
    end

    // The lookup reads disp_nxt so a message latched at the boundary is
    // already used for slot 0 of the frame that boundary opens.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            chars[i] = disp_nxt[i*CHAR_W +: CHAR_W];
        end
    end
    assign code_sel = chars[slot];

    char_glyph_rom u_glyph_rom (
        .code  (code_sel),
        .glyph (glyph)
    );

    // Slot FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_GUARD;
        end else begin
            state <= state_nxt;
        end
    end

    // Slot FSM: next state tracks which window tick_nxt falls into
    always_comb begin
        state_nxt = state;
        case (state)
            ST_GUARD: if (tick_nxt >= GUARD_END) state_nxt = ST_DRIVE;
            ST_DRIVE: if (tick_nxt <  GUARD_END) state_nxt = ST_GUARD;
            default:  state_nxt = ST_GUARD;
        endcase
    end

    // Slot FSM: outputs
    always_comb begin
        an_d  = 8'hFF;
        led_d = 7'h7F;
        if (state == ST_DRIVE && !blink_phase_nxt) begin
            an_d  = ~(8'b1 << slot);
            led_d = glyph;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick        <= '0;
            slot        <= '0;
            disp_msg    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            AN          <= 8'hFF;
            led         <= 7'h7F;
            msg_ready   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            tick        <= tick_nxt;
            slot        <= slot_nxt;
            disp_msg    <= disp_nxt;
            blink_cnt   <= blink_cnt_nxt;
            blink_phase <= blink_phase_nxt;
            AN          <= an_d;
            led         <= led_d;
            msg_ready   <= slot_end;
            frame_start <= frame_edge;
        end
    end

endmodule

// File: tb/tb_msg_scan_driver.sv
// tb/tb_msg_scan_driver.sv - scoreboard bench for msg_scan_driver
module tb_msg_scan_driver;

    localparam int RD = 8;
    localparam int GT = 2;
    localparam int BF = 2;
    localparam int FT = 8 * RD;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [39:0] msg = '0;
    logic        msg_valid = 1'b0;
    logic        blink = 1'b0;
    logic        msg_ready;
    logic [7:0]  AN;
    logic [6:0]  led;
    logic        frame_start;

    msg_scan_driver #(
        .REFRESH_DIV  (RD),
        .GUARD_TICKS  (GT),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .msg         (msg),
        .msg_valid   (msg_valid),
        .msg_ready   (msg_ready),
        .blink       (blink),
        .AN          (AN),
        .led         (led),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] m;
        bit          ph;
    } frame_t;

    frame_t      exp_q[$];
    frame_t      cur;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    int          mon_n = 0;
    logic [39:0] model_msg = '0;
    int          blink_run = 0;
    bit          sched_prev = 1'b0;

    localparam logic [39:0] MSG_US = 40'h0000005660;  // "U","S",blank in slots 2,1,0

    function automatic logic [6:0] glyph_of(input logic [4:0] c);
        case (c)
            5'd1:    return 7'h08;
            5'd5:    return 7'h30;
            5'd19:   return 7'h24;
            5'd21:   return 7'h41;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [39:0] rand_msg();
        logic [4:0]  codes [7] = '{5'd0, 5'd1, 5'd5, 5'd19, 5'd21, 5'd27, 5'd31};
        logic [39:0] r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i*5 +: 5] = codes[$urandom_range(0, 6)];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, mon_n);
        end
    endtask

    function automatic bit phase_of(input int run);
        if (run == 0) return 1'b0;
        return bit'(((run - 1) / BF) % 2);
    endfunction

    // Called in the last cycle of a frame: the inputs now present are what the
    // boundary edge samples, which fixes the content of the coming frame.
    task automatic push_frame(input bit first);
        frame_t f;
        if (!first && msg_valid) model_msg = msg;
        blink_run = blink ? blink_run + 1 : 0;
        f.m  = model_msg;
        f.ph = phase_of(blink_run);
        exp_q.push_back(f);
    endtask

    always @(negedge clk) begin
        int slot;
        int tick;
        logic [7:0] ea;
        logic [6:0] el;
        if (mon_en) begin
            if (mon_n % FT == 0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard: actual empty required frame entry (cycle %0d)", mon_n);
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            slot = (mon_n / RD) % 8;
            tick = mon_n % RD;
            if (cur.ph || tick < GT) begin
                ea = 8'hFF;
                el = 7'h7F;
            end else begin
                ea = ~(8'(1) << slot);
                el = glyph_of(cur.m[slot*5 +: 5]);
            end
            check("AN", 32'(AN), 32'(ea));
            check("led", 32'(led), 32'(el));
            check("frame_start", 32'(frame_start), 32'(mon_n % FT == 0));
            check("msg_ready", 32'(msg_ready), 32'(mon_n % FT == FT - 1));
            mon_n++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_AN"}, 32'(AN), 32'h0FF);
        check({tag, "_led"}, 32'(led), 32'h07F);
        check({tag, "_msg_ready"}, 32'(msg_ready), 32'h0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'h0);
    endtask

    task automatic release_reset();
        exp_q.delete();
        model_msg  = '0;
        blink_run  = 0;
        sched_prev = 1'b0;
        blink      = 1'b0;
        push_frame(1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_n  = 0;
        mon_en = 1'b1;
    endtask

    function automatic bit blink_sched(input int b);
        if (b >= 3 && b < 12) return 1'b1;
        if (b < 15) return 1'b0;
        if ($urandom_range(0, 3) == 0) return ~sched_prev;
        return sched_prev;
    endfunction

    task automatic run_cycles(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            int pos;
            int b;
            pos = c % FT;
            b   = c / FT + 1;
            if (pos == FT - 1) begin
                blink      = blink_sched(b);
                sched_prev = blink;
                msg_valid  = (b == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                msg        = (b == 1) ? MSG_US : rand_msg();
                push_frame(1'b0);
            end else begin
                if ($urandom_range(0, 3) == 0) msg = rand_msg();
                msg_valid = 1'($urandom_range(0, 1));
                blink     = 1'($urandom_range(0, 1));
                if (pos == 3 * RD) begin
                    msg       = rand_msg();
                    msg_valid = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        msg_valid = 1'b1;
        msg       = MSG_US;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        release_reset();
        run_cycles(20 * FT + 5 * RD + 3);

        // Reset in slot 5 with a valid message pending: nothing may be latched.
        mon_en    = 1'b0;
        reset     = 1'b0;
        msg_valid = 1'b1;
        msg       = MSG_US;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        run_cycles(10 * FT);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
